// File: rtl/dma_csr_initiator.sv
// Wishbone classic master that programs the M2M DMA CSR block and tracks a transfer to completion.
// Optional watchdog on the completion wait is enabled by defining DMA_CSR_INIT_TIMEOUT_EN.
module dma_csr_initiator #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       POLL_GAP  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [31:0]       cmd_src_i,
    input  logic [31:0]       cmd_dst_i,
    input  logic [15:0]       cmd_len_i,
    input  logic              cmd_ie_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              dma_irq_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [3:0] {
        StIdle,
        StWrSrc,
        StWrDst,
        StWrLen,
        StWrCtrl,
        StWaitPoll,
        StRdStat,
        StWaitIrq,
        StClrStat,
        StDone,
        StFail
    } state_e;

    localparam logic [7:0]  OffSrc  = 8'h00;
    localparam logic [7:0]  OffDst  = 8'h04;
    localparam logic [7:0]  OffLen  = 8'h08;
    localparam logic [7:0]  OffCtrl = 8'h0C;
    localparam logic [7:0]  OffStat = 8'h10;
    localparam logic [31:0] DoneIf  = 32'h0001_0000;
    localparam logic [7:0]  PollLast = 8'(POLL_GAP - 1);

    state_e state_q, state_d;

    logic [31:0] src_q, dst_q;
    logic [15:0] len_q;
    logic        ie_q;

    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [7:0]        poll_cnt_q, poll_cnt_d;

    logic        accept;
    logic        bus_state;
    logic        bus_we;
    logic [7:0]  bus_off;
    logic [31:0] bus_wdata;
    logic        bus_err;
    logic        bus_ack;

    // Only DONE_IF is used from STATUS; the rest of the read word is intentionally dropped.
    logic unused_rdata;
    assign unused_rdata = ^{wb_dat_i[31:17], wb_dat_i[15:0]};

`ifdef DMA_CSR_INIT_TIMEOUT_EN
    logic [19:0] wdog_q, wdog_d;
`endif

    assign accept  = (state_q == StIdle) && cmd_valid_i;
    // err wins over ack when both are raised
    assign bus_err = cyc_q && wb_err_i;
    assign bus_ack = cyc_q && wb_ack_i && !wb_err_i;

    // Per-state bus transaction description
    always_comb begin
        bus_state = 1'b1;
        bus_we    = 1'b1;
        bus_off   = OffSrc;
        bus_wdata = 32'h0;
        case (state_q)
            StWrSrc: begin
                bus_off   = OffSrc;
                bus_wdata = src_q;
            end
            StWrDst: begin
                bus_off   = OffDst;
                bus_wdata = dst_q;
            end
            StWrLen: begin
                bus_off   = OffLen;
                bus_wdata = {16'h0, len_q};
            end
            StWrCtrl: begin
                bus_off   = OffCtrl;
                bus_wdata = {30'h0, ie_q, 1'b1};
            end
            StRdStat: begin
                bus_off = OffStat;
                bus_we  = 1'b0;
            end
            StClrStat: begin
                bus_off   = OffStat;
                bus_wdata = DoneIf;
            end
            default: bus_state = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        poll_cnt_d = poll_cnt_q;
`ifdef DMA_CSR_INIT_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif

        // Bus request launches the cycle after state entry and drops on the response edge.
        if (bus_state) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                we_d  = bus_we;
                adr_d = BASE_ADDR + ADDR_W'(bus_off);
                dat_d = bus_wdata;
            end else if (wb_ack_i || wb_err_i) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
            end
        end

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    state_d = (cmd_len_i == 16'h0) ? StDone : StWrSrc;
                end
            end
            StWrSrc: begin
                if (bus_err)      state_d = StFail;
                else if (bus_ack) state_d = StWrDst;
            end
            StWrDst: begin
                if (bus_err)      state_d = StFail;
                else if (bus_ack) state_d = StWrLen;
            end
            StWrLen: begin
                if (bus_err)      state_d = StFail;
                else if (bus_ack) state_d = StWrCtrl;
            end
            StWrCtrl: begin
                if (bus_err) begin
                    state_d = StFail;
                end else if (bus_ack) begin
                    state_d    = ie_q ? StWaitIrq : StWaitPoll;
                    poll_cnt_d = 8'h0;
                end
            end
            StWaitPoll: begin
                if (poll_cnt_q == PollLast) begin
                    state_d    = StRdStat;
                    poll_cnt_d = 8'h0;
                end else begin
                    poll_cnt_d = poll_cnt_q + 8'h1;
                end
            end
            StRdStat: begin
                if (bus_err) begin
                    state_d = StFail;
                end else if (bus_ack) begin
                    state_d    = wb_dat_i[16] ? StClrStat : StWaitPoll;
                    poll_cnt_d = 8'h0;
                end
            end
            StWaitIrq: begin
                if (dma_irq_i) state_d = StClrStat;
            end
            StClrStat: begin
                if (bus_err)      state_d = StFail;
                else if (bus_ack) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

`ifdef DMA_CSR_INIT_TIMEOUT_EN
        // Held clear through WR_CTRL so the wait phase always starts from zero.
        if (state_q == StWrCtrl) begin
            wdog_d = 20'h0;
        end else if (state_q == StWaitPoll || state_q == StRdStat || state_q == StWaitIrq) begin
            if (wdog_q == 20'hFFFFF) begin
                state_d = StFail;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end else begin
                wdog_d = wdog_q + 20'h1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= 32'h0;
            poll_cnt_q <= 8'h0;
            src_q      <= 32'h0;
            dst_q      <= 32'h0;
            len_q      <= 16'h0;
            ie_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            poll_cnt_q <= poll_cnt_d;
            if (accept) begin
                src_q <= cmd_src_i;
                dst_q <= cmd_dst_i;
                len_q <= cmd_len_i;
                ie_q  <= cmd_ie_i;
            end
        end
    end

`ifdef DMA_CSR_INIT_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) wdog_q <= 20'h0;
        else         wdog_q <= wdog_d;
    end
`endif

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = {4{cyc_q}};
    assign cmd_ready_o = (state_q == StIdle);
    assign busy_o      = !(state_q == StIdle || state_q == StDone || state_q == StFail);
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StFail);

endmodule

// File: tb/tb_dma_csr_initiator.sv
// Scoreboard bench for dma_csr_initiator: randomized descriptors against a transaction-level model,
// with a reactive Wishbone slave providing latency, STATUS data, error injection and the DMA irq.
module tb_dma_csr_initiator;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int unsigned GAP    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src = '0;
    logic [31:0] cmd_dst = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_ie = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdata = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        irq = 1'b0;
    logic        busy, done, err;

    always #5 clk = ~clk;

    dma_csr_initiator #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .POLL_GAP (GAP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_src_i  (cmd_src),
        .cmd_dst_i  (cmd_dst),
        .cmd_len_i  (cmd_len),
        .cmd_ie_i   (cmd_ie),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel),
        .wb_dat_i   (wb_rdata),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err),
        .dma_irq_i  (irq),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    typedef enum int {EvBus, EvDone, EvErr} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] stat_q[$];
    int          err_q[$];
    int          irq_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    bit          sb_en = 1'b1;
    logic [31:0] stat_dflt = 32'h0001_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a bus transfer or pulses done/err.
    bit pulse_seen = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (sb_en && rst_n) begin
            if (pulse_seen) check("ready_after_pulse", cmd_ready, 1);
            pulse_seen = 1'b0;
            if (wb_cyc && (wb_ack || wb_err)) begin
                check("stb_with_cyc", wb_stb, 1);
                check("sel", wb_sel, 4'hF);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_bus: got adr %h we %b, required no transfer",
                             wb_adr, wb_we);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_bus", e.kind, EvBus);
                    check("bus_we", wb_we, e.we);
                    check("bus_adr", wb_adr, e.adr);
                    if (e.we) check("bus_wdata", wb_dat_o, e.dat);
                end
            end
            if (done || err) begin
                pulse_seen = 1'b1;
                check("busy_at_pulse", busy, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got done %b err %b, required none", done, err);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_pulse", done ? EvDone : EvErr, e.kind);
                end
            end
        end
    end

    // Wishbone slave: random latency, STATUS data from stat_q, per-descriptor error slot and irq.
    int txn_idx = 0, cur_err = -1, cur_irq = 0, wait_left = 0, irq_timer = 0;
    bit in_txn = 1'b0, irq_armed = 1'b0;
    always begin
        @(posedge clk);
        #1;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_rdata = '0;
        if (irq_armed) begin
            if (irq_timer == 0) begin
                irq       = 1'b1;
                irq_armed = 1'b0;
            end else begin
                irq_timer--;
            end
        end
        if (!rst_n) begin
            in_txn    = 1'b0;
            irq       = 1'b0;
            irq_armed = 1'b0;
        end else if (wb_cyc && wb_stb) begin
            if (!in_txn) begin
                in_txn    = 1'b1;
                wait_left = $urandom_range(0, 2);
                if (wb_we && wb_adr == BASE) begin
                    txn_idx   = 0;
                    cur_err   = (err_q.size() != 0) ? err_q.pop_front() : -1;
                    cur_irq   = (irq_q.size() != 0) ? irq_q.pop_front() : 0;
                    irq       = 1'b0;
                    irq_armed = 1'b0;
                end else begin
                    txn_idx++;
                end
            end
            if (wait_left == 0) begin
                in_txn = 1'b0;
                if (txn_idx == cur_err) begin
                    wb_err = 1'b1;
                end else begin
                    wb_ack = 1'b1;
                    if (!wb_we) begin
                        wb_rdata = (stat_q.size() != 0) ? stat_q.pop_front() : stat_dflt;
                    end else if (wb_adr == BASE + 32'hC && wb_dat_o[1]) begin
                        irq_armed = 1'b1;
                        irq_timer = cur_irq;
                    end else if (wb_adr == BASE + 32'h10) begin
                        irq = 1'b0;
                    end
                end
            end else begin
                wait_left--;
            end
        end
    end

    // Reference model: expected CSR traffic for one descriptor, then hand it to the DUT.
    task automatic send(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                        input logic ie, input int nbusy, input int err_idx, input int irq_dly,
                        input bit directed);
        ev_t         txns[$];
        logic [31:0] stats[$];
        logic [31:0] s;
        int          guard;
        bit          failed;
        if (len == 16'h0) begin
            exp_q.push_back('{EvDone, 1'b0, 32'h0, 32'h0});
        end else begin
            txns.push_back('{EvBus, 1'b1, BASE,          src});
            txns.push_back('{EvBus, 1'b1, BASE + 32'h4,  dst});
            txns.push_back('{EvBus, 1'b1, BASE + 32'h8,  {16'h0, len}});
            txns.push_back('{EvBus, 1'b1, BASE + 32'hC,  ie ? 32'h3 : 32'h1});
            if (!ie) begin
                for (int k = 0; k <= nbusy; k++) begin
                    if (k < nbusy) s = directed ? 32'h1 : (($urandom & ~32'h0001_0000) | 32'h1);
                    else           s = directed ? 32'h0001_0000 : ($urandom | 32'h0001_0000);
                    stats.push_back(s);
                    txns.push_back('{EvBus, 1'b0, BASE + 32'h10, 32'h0});
                end
            end
            txns.push_back('{EvBus, 1'b1, BASE + 32'h10, 32'h0001_0000});
            failed = (err_idx >= 0) && (err_idx < txns.size());
            for (int i = 0; i < txns.size(); i++) begin
                if (failed && i > err_idx) break;
                exp_q.push_back(txns[i]);
                if (!txns[i].we && !(failed && i == err_idx)) stat_q.push_back(stats[i - 4]);
            end
            exp_q.push_back(failed ? '{EvErr, 1'b0, 32'h0, 32'h0} : '{EvDone, 1'b0, 32'h0, 32'h0});
            err_q.push_back(err_idx);
            irq_q.push_back(irq_dly);
        end
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_ie    = ie;
        cmd_valid = 1'b1;
        guard     = 0;
        while (!cmd_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                $display("FAIL accept_timeout: got cmd_ready 0 for %0d cycles, required 1", guard);
                $fatal(1, "accept wait expired");
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (len == 16'h0) begin
            check("zero_len_done_next", done, 1);
        end else begin
            check("busy_after_accept", busy, 1);
            check("ready_low_when_busy", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int guard;
        int ntx;
        int eidx;
        logic        ie;
        logic [15:0] len;

        repeat (3) @(negedge clk);
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 0);
        check("rst_adr", wb_adr, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_sel", wb_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h2000, 32'h3000, 16'h0040, 1'b0, 2, -1, 0, 1'b1);
        send(32'h2100, 32'h3100, 16'h0080, 1'b1, 0, -1, 50, 1'b1);
        send(32'h2200, 32'h3200, 16'h0000, 1'b0, 0, -1, 0, 1'b1);
        send(32'h2300, 32'h3300, 16'h0010, 1'b0, 1, 2, 0, 1'b1);
        drain("directed_drain");

        for (int n = 0; n < 40; n++) begin
            ie   = 1'($urandom_range(0, 1));
            len  = ($urandom_range(0, 6) == 0) ? 16'h0 : 16'($urandom);
            ntx  = $urandom_range(0, 3);
            eidx = -1;
            if ($urandom_range(0, 3) == 0) eidx = $urandom_range(0, ie ? 4 : 5 + ntx);
            send($urandom, $urandom, len, ie, ntx, eidx, $urandom_range(0, 60), 1'b0);
        end
        drain("random_drain");

        // Reset while a STATUS read is open: bus must drop next cycle with no pulses.
        sb_en     = 1'b0;
        stat_dflt = 32'h1;
        cmd_src   = 32'h4000;
        cmd_dst   = 32'h5000;
        cmd_len   = 16'h0020;
        cmd_ie    = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!(wb_cyc && !wb_we) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_rd_stat", wb_cyc && !wb_we, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_cyc", wb_cyc, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_done", done, 0);
        check("rst_mid_err", err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_pulse", {done, err, wb_cyc}, 3'b000);
        end
        stat_q.delete();
        err_q.delete();
        irq_q.delete();
        exp_q.delete();
        stat_dflt = 32'h0001_0000;
        sb_en     = 1'b1;

        send(32'h6000, 32'h7000, 16'h0100, 1'b0, 1, -1, 0, 1'b0);
        drain("recovery_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_csr_initiator.md
Name: dma_csr_initiator

Overview:
- Wishbone classic-cycle master that programs the M2M DMA's CSR slave and tracks the transfer to completion.
- Accepts one transfer descriptor on a valid/ready command port.
- Writes SOURCE_ADDR, DEST_ADDR, LENGTH and CONTROL(GO), then waits for completion by polling STATUS or by waiting on the DMA interrupt.
- Clears DONE_IF and reports done or error.
- Sits between a host-side sequencer (or test harness) and the DMA CSR bus port.

Parameters:
- ADDR_W, 32, Wishbone address width.
- BASE_ADDR, 32'h0000_0000, byte base of the DMA CSR window; register offsets are added to it.
- POLL_GAP, 8, idle cycles between STATUS reads (1..255).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- cmd_valid_i  in  1  descriptor valid
- cmd_ready_o  out  1  descriptor accepted when valid&ready
- cmd_src_i  in  32  source address
- cmd_dst_i  in  32  destination address
- cmd_len_i  in  16  length
- cmd_ie_i  in  1  use interrupt instead of polling
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADDR_W  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects (always 4'hF when stb)
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error
- dma_irq_i  in  1  DMA done interrupt, level
- busy_o  out  1  descriptor in flight
- done_o  out  1  one-cycle pulse on successful completion
- err_o  out  1  one-cycle pulse on bus error or timeout

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-low, on rst_ni.
- Reset values:
  - All wb_* outputs 0.
  - busy_o, done_o, err_o = 0.
  - cmd_ready_o = 1.
  - FSM in IDLE; poll counter 0.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch src/dst/len/ie and set busy_o next cycle.
  - If len==0: no bus traffic; done_o pulses the cycle after accept; FSM returns to IDLE.
- Write sequence: WR_SRC (off 0x00, data src) -> WR_DST (0x04, dst) -> WR_LEN (0x08, {16'h0,len}) -> WR_CTRL (0x0C, {30'h0,ie,1'b1}).
- Bus states:
  - cyc/stb/we/adr/dat/sel are registered and asserted the cycle after state entry.
  - They are held stable until wb_ack_i or wb_err_i is sampled high.
  - cyc/stb drop the same edge the ack/err is sampled, so there is one idle cycle between transactions.
- After WR_CTRL:
  - ie=0: go to WAIT_POLL.
  - ie=1: go to WAIT_IRQ.
- WAIT_POLL: count POLL_GAP cycles, then go to RD_STAT.
- RD_STAT (0x10, read):
  - On ack, if wb_dat_i[16]==1 (DONE_IF), go to CLR_STAT.
  - Otherwise return to WAIT_POLL. BUSY bit[0] is ignored for the decision.
- WAIT_IRQ: on dma_irq_i==1, go to CLR_STAT. No polling in this state.
- CLR_STAT: write 0x0001_0000 to 0x10 (W1C DONE_IF). On ack, go to DONE.
- DONE: done_o=1 for one cycle, busy_o=0, return to IDLE; cmd_ready_o=1 the following cycle.
- Error handling:
  - wb_err_i in any bus state drops the cycle and goes to FAIL.
  - FAIL: err_o pulses 1 cycle, busy_o clears, return to IDLE. No retry, no clear write.
- ack and err high together: err wins.
- cmd_valid_i while busy: ignored (cmd_ready_o=0); the descriptor is not dropped by the initiator, only back-pressured.
- Reset mid-transfer:
  - The bus is released the cycle after rst_ni is sampled low.
  - In-flight descriptor is discarded; no done_o/err_o pulse.
- Addresses: BASE_ADDR+offset, computed in ADDR_W bits, wrap modulo 2^ADDR_W.

Optional Feature:
- DMA_CSR_INIT_TIMEOUT_EN defined:
  - A 20-bit watchdog counter clears on entry to WAIT_POLL/WAIT_IRQ from WR_CTRL.
  - It increments every cycle in WAIT_POLL, RD_STAT and WAIT_IRQ.
  - On reaching 20'hFFFFF it forces FAIL (err_o pulse); any open bus cycle is dropped first.
- Undefined: no counter; waits indefinitely.

Test Plan:
- Poll path:
  - Stimulus: BASE_ADDR=0x1000, cmd src=0x2000 dst=0x3000 len=0x0040 ie=0.
  - Writes required: 0x1000=0x2000, 0x1004=0x3000, 0x1008=0x40, 0x100C=0x1.
  - STATUS reads return 0x1 twice, then 0x10000.
  - Then a write of 0x10000 to 0x1010 is required, and done_o pulses once.
- IRQ path: ie=1 -> CONTROL write data 0x3; no STATUS reads. dma_irq_i raised 50 cycles later -> clear write, then done_o.
- Zero length: len=0 -> no cyc_o asserted, done_o one cycle after accept.
- Bus error: wb_err_i on the WR_LEN ack slot -> no CONTROL write, err_o pulse, busy_o=0, cmd_ready_o=1 next cycle.
- Back-pressure/reset: cmd_valid_i held during an active transfer -> second descriptor accepted only after done_o. rst_ni low during RD_STAT -> cyc_o=0 next cycle, no pulses.
- Timeout (DMA_CSR_INIT_TIMEOUT_EN): STATUS always 0x1 -> err_o after 2^20-1 wait cycles.
